// File: rtl/case_enc_pkg.sv
// Shared types and constants for the casez priority encoder family.
// Optional X/Z screening in the top level is enabled with macro XZ_CHECK_EN.
package case_enc_pkg;

  // Default build-time sizes for the encoder
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  // Widest request vector the casez table covers, and the index width it needs
  localparam int MAX_WIDTH = 16;
  localparam int IDX_MAX_W = 4;

  // Bit positions of the flags inside a packed enc_res_t
  localparam int RES_MULTI_BIT = 0;
  localparam int RES_NONE_BIT  = 1;
  localparam int RES_IDX_LSB   = 2;

  // Encoded result: index of the highest set bit plus none/multi flags
  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic                 none;
    logic                 multi;
  } enc_res_t;

  // Output register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hs_state_t;

  // Index width for an n-entry vector, never narrower than one bit
  function automatic int clog2_w(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/case_z_prio_core.sv
// Combinational MSB-priority match using a casez table, plus a multi-hit flag.
// The request is zero-extended to the widest supported vector, so a single
// 16-entry table serves every legal WIDTH.
module case_z_prio_core
  import case_enc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_req,
  output enc_res_t         o_res
);

  logic [MAX_WIDTH-1:0] w_pad;
  logic [IDX_MAX_W-1:0] w_idx;
  logic                 w_none;
  logic                 w_multi;

  assign w_pad = MAX_WIDTH'(i_req);

  // Highest set bit wins; the leading-zero prefix in each pattern keeps them disjoint
  always_comb begin
    w_idx  = '0;
    w_none = 1'b0;
    casez (w_pad)
      16'b1???_????_????_????: w_idx = 4'd15;
      16'b01??_????_????_????: w_idx = 4'd14;
      16'b001?_????_????_????: w_idx = 4'd13;
      16'b0001_????_????_????: w_idx = 4'd12;
      16'b0000_1???_????_????: w_idx = 4'd11;
      16'b0000_01??_????_????: w_idx = 4'd10;
      16'b0000_001?_????_????: w_idx = 4'd9;
      16'b0000_0001_????_????: w_idx = 4'd8;
      16'b0000_0000_1???_????: w_idx = 4'd7;
      16'b0000_0000_01??_????: w_idx = 4'd6;
      16'b0000_0000_001?_????: w_idx = 4'd5;
      16'b0000_0000_0001_????: w_idx = 4'd4;
      16'b0000_0000_0000_1???: w_idx = 4'd3;
      16'b0000_0000_0000_01??: w_idx = 4'd2;
      16'b0000_0000_0000_001?: w_idx = 4'd1;
      16'b0000_0000_0000_0001: w_idx = 4'd0;
      default: begin
        w_idx  = '0;
        w_none = 1'b1;
      end
    endcase
  end

  // Clearing the lowest set bit leaves something only if two or more were set
  assign w_multi = |(i_req & (i_req - WIDTH'(1)));

  assign o_res.idx   = w_idx;
  assign o_res.none  = w_none;
  assign o_res.multi = w_multi;

endmodule

// File: rtl/case_z_prio_enc.sv
// Registered MSB-priority encoder behind a valid/ready handshake, with one
// output register stage and a saturating count of multi-hit vectors.
// Define XZ_CHECK_EN to flag (sticky) and neutralise request vectors holding X/Z.
module case_z_prio_enc
  import case_enc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = clog2_w(WIDTH),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_none,
  output logic             out_multi,
  output logic [CNT_W-1:0] multi_cnt,
  output logic             xz_err
);

  hs_state_t        r_state;
  hs_state_t        w_state_nxt;
  enc_res_t         w_core_res;
  enc_res_t         w_load_res;
  enc_res_t         r_res;
  logic             w_accept;
  logic [CNT_W-1:0] r_multi_cnt;
  logic             w_unused_idx;

  case_z_prio_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_req(in_req),
    .o_res(w_core_res)
  );

  // Occupancy of the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Fill on accept, empty when the consumer takes the result and nothing replaces it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Ready depends only on occupancy and out_ready, never on in_valid
  always_comb begin
    out_valid = (r_state == ST_FULL);
    in_ready  = (r_state == ST_EMPTY) || out_ready;
  end

  assign w_accept = in_valid && in_ready;

`ifdef XZ_CHECK_EN
  logic w_xz_hit;
  logic r_xz_err;

  assign w_xz_hit = ((^in_req) === 1'bx);

  // A poisoned vector is reported as "no request" so it cannot look like a hit
  always_comb begin
    w_load_res = w_core_res;
    if (w_xz_hit) begin
      w_load_res      = '0;
      w_load_res.none = 1'b1;
    end
  end

  // Sticky until reset so a single bad vector is never missed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_xz_err <= 1'b0;
    else if (w_accept && w_xz_hit) r_xz_err <= 1'b1;
  end

  assign xz_err = r_xz_err;
`else
  assign w_load_res = w_core_res;
  assign xz_err     = 1'b0;
`endif

  // Result register loads on every accept, including the drain-and-refill edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_res <= '0;
    else if (w_accept) r_res <= w_load_res;
  end

  // Count accepted multi-hit vectors, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_multi_cnt <= '0;
    end else if (w_accept && w_load_res.multi && (r_multi_cnt != {CNT_W{1'b1}})) begin
      r_multi_cnt <= r_multi_cnt + CNT_W'(1);
    end
  end

  assign out_idx      = r_res.idx[IDX_W-1:0];
  assign out_none     = r_res[RES_NONE_BIT];
  assign out_multi    = r_res[RES_MULTI_BIT];
  assign multi_cnt    = r_multi_cnt;
  assign w_unused_idx = ^r_res.idx;

endmodule

// File: doc/case_z_prio_enc.md
Name: case_z_prio_enc

Overview:
- Registered priority encoder: the inverse direction of the team's casex/casez decoder blocks.
- Takes a WIDTH-bit request vector and returns the index of the highest set bit, plus none/multi flags.
- Matching uses casez don't-care patterns (1??? etc.).
- Sits between request sources and downstream consumers behind a valid/ready handshake, with one output register stage and a saturating collision counter.

Parameters:
- WIDTH, 4, request vector width; legal range 2..16.
- IDX_W, $clog2(WIDTH), width of the encoded index (derived; do not override).
- CNT_W, 8, width of the multi-hit saturating counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request vector valid.
- in_ready  output  1  block can accept in_req this cycle.
- in_req  input  WIDTH  request vector.
- out_valid  output  1  encoded result valid.
- out_ready  input  1  downstream accepts the result.
- out_idx  output  IDX_W  index of the highest set request bit.
- out_none  output  1  accepted vector was all zeros.
- out_multi  output  1  accepted vector had more than one bit set.
- multi_cnt  output  CNT_W  saturating count of accepted vectors with out_multi=1.
- xz_err  output  1  input contained X/Z (only driven when XZ_CHECK_EN is defined, else tied 0).

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_idx=0, out_none=0, out_multi=0, multi_cnt=0, xz_err=0.
  - Reset mid-transfer discards the held result; nothing is replayed.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational from out_ready only; no path from in_valid).
  - Accept when in_valid && in_ready.
- Latency: exactly 1 cycle. The result registers on the accept edge; out_valid goes high the next cycle.
- Hold: while out_valid && !out_ready, out_idx, out_none and out_multi are held stable.
- Simultaneous out_ready and a new accept: the output register reloads in the same edge, so out_valid stays 1 and there is no bubble. Full throughput is 1 vector per cycle.
- Drain: out_ready=1 with no accept clears out_valid next edge. out_idx keeps its last value (don't-care while invalid).
- Encoding is MSB priority:
  - out_idx = highest i with in_req[i]=1.
  - in_req=0: out_idx=0, out_none=1.
  - out_multi = popcount(in_req) > 1.
- multi_cnt increments on each accept with out_multi=1, saturating at 2^CNT_W-1 with no wrap. It is not cleared by reads.
- Implicit two-state control: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready without accept.
  - FULL -> FULL on hold, or on ready+accept.

Optional Feature:
- Macro XZ_CHECK_EN (simulation use).
- Defined:
  - On accept, if in_req contains any X or Z bit (reduction-XOR === 1'bx), xz_err is set sticky until reset.
  - The result is forced to out_idx=0, out_none=1, out_multi=0, and multi_cnt is not incremented.
- Undefined: xz_err is tied 0 and no X/Z checking is performed; encoding follows casez semantics.

Decomposition:
- Package case_enc_pkg holds:
  - default WIDTH and CNT_W;
  - a function clog2_w;
  - localparam constants for the none/multi flag bit positions in a packed result struct: typedef enc_res_t {idx, none, multi}.
- One natural combinational sub-module, case_z_prio_core: casez-based MSB priority match plus popcount>1, producing enc_res_t.
- The top level owns the handshake register, the counter and the optional X/Z logic.

Test Plan:
- Reset then in_req=4'b0000 accepted -> next cycle out_valid=1, out_idx=0, out_none=1, out_multi=0.
- Sweep one-hot in_req=0001,0010,0100,1000 back-to-back with out_ready=1 -> out_idx 0,1,2,3 on consecutive cycles, out_multi=0, no bubbles.
- in_req=4'b1011 -> out_idx=3, out_multi=1, multi_cnt=1; in_req=4'b0110 -> out_idx=2, multi_cnt=2.
- Backpressure: hold out_ready=0 for 3 cycles after an accept of 4'b0100 -> in_ready=0, out_idx=2 stable; release -> transfer completes and the next queued vector loads the same edge.
- CNT_W=2, 5 multi-hit accepts -> multi_cnt saturates at 3.
- XZ_CHECK_EN defined, in_req=4'b1x01 accepted -> xz_err=1 (sticky), out_none=1, multi_cnt unchanged; assert rst_n=0 mid-hold -> all outputs 0 immediately.
